// File: rtl/rounder_normshift_if.sv
// Operand-in / result-out handshake bundle for the rounder normalisation-shift stage.
interface rounder_normshift_if #(
    parameter int EW  = 13,
    parameter int LZW = 6,
    parameter int FW  = 64
);
    logic           in_valid;
    logic           in_ready;
    logic [EW-1:0]  er;
    logic [LZW-1:0] lz;
    logic [FW-1:0]  fin;
    logic [1:0]     fmt;
    logic           tiny;
    logic           unfen;
    logic           out_valid;
    logic           out_ready;
    logic [EW-1:0]  sh;
    logic [FW-1:0]  fout;
    logic [EW-1:0]  eout;
    logic           sticky;

    modport slave (
        input  in_valid, er, lz, fin, fmt, tiny, unfen, out_ready,
        output in_ready, out_valid, sh, fout, eout, sticky
    );

    modport master (
        output in_valid, er, lz, fin, fmt, tiny, unfen, out_ready,
        input  in_ready, out_valid, sh, fout, eout, sticky
    );
endinterface

// File: rtl/rounder_normshift.sv
// Three-stage normalise/denormalise shifter: S1 shift distance, S2 coarse (x8) shift,
// S3 fine shift and sticky; valid/ready with bubble collapsing.
module rounder_normshift #(
    parameter int EW     = 13,
    parameter int LZW    = 6,
    parameter int FW     = 64,
    parameter int EMIN_H = -14,
    parameter int EMIN_S = -126,
    parameter int EMIN_D = -1022
) (
    input logic               clk,
    input logic               rst,
    rounder_normshift_if.slave io
);
    localparam int SW = $clog2(FW);
    localparam logic [EW-1:0] EMIN_H_E = EW'(EMIN_H);
    localparam logic [EW-1:0] EMIN_S_E = EW'(EMIN_S);
    localparam logic [EW-1:0] EMIN_D_E = EW'(EMIN_D);
    localparam logic [EW-1:0] FW_E     = EW'(FW);

    logic v1_q, v2_q, v3_q;
    logic rdy1, rdy2, rdy3;
    logic ld1, ld2, ld3;

    // A stage accepts when empty or when its occupant moves on this cycle.
    assign rdy3 = !v3_q || io.out_ready;
    assign rdy2 = !v2_q || rdy3;
    assign rdy1 = !v1_q || rdy2;
    assign ld1  = io.in_valid && rdy1;
    assign ld2  = v1_q && rdy2;
    assign ld3  = v2_q && rdy3;

    logic [EW-1:0] emin, mag, sh1_d, eout1_d;
    logic          neg1_d, sat1_d;
    logic [SW-1:0] amt1_d;

    always_comb begin
        case (io.fmt)
            2'b00:   emin = EMIN_H_E;
            2'b01:   emin = EMIN_S_E;
            default: emin = EMIN_D_E;
        endcase
        if (io.tiny && !io.unfen) begin
            sh1_d = io.er - emin;
        end else begin
            sh1_d = {{(EW-LZW){1'b0}}, io.lz};
        end
        eout1_d = io.er - sh1_d;
        neg1_d  = sh1_d[EW-1];
        mag     = neg1_d ? -sh1_d : sh1_d;
        sat1_d  = (mag >= FW_E);
        amt1_d  = sat1_d ? '0 : mag[SW-1:0];
    end

    logic [FW-1:0] fin1_q;
    logic [EW-1:0] sh1_q, eout1_q;
    logic          neg1_q, sat1_q;
    logic [SW-1:0] amt1_q;

    logic [SW-1:0] crs;
    logic [FW-1:0] f2_d;
    logic          st2_d;

    // Saturated shifts zero the significand here; the fine amount is already 0.
    always_comb begin
        crs = {amt1_q[SW-1:3], 3'b000};
        if (sat1_q) begin
            f2_d = '0;
        end else if (neg1_q) begin
            f2_d = fin1_q >> crs;
        end else begin
            f2_d = fin1_q << crs;
        end
        if (!neg1_q) begin
            st2_d = 1'b0;
        end else if (sat1_q) begin
            st2_d = |fin1_q;
        end else begin
            st2_d = |(fin1_q & ~({FW{1'b1}} << crs));
        end
    end

    logic [FW-1:0] f2_q;
    logic          st2_q, neg2_q;
    logic [2:0]    fine2_q;
    logic [EW-1:0] sh2_q, eout2_q;

    logic [FW-1:0] f3_d;
    logic          st3_d;

    always_comb begin
        f3_d  = neg2_q ? (f2_q >> fine2_q) : (f2_q << fine2_q);
        st3_d = st2_q | (neg2_q && |(f2_q & ~({FW{1'b1}} << fine2_q)));
    end

    logic [FW-1:0] f3_q;
    logic          st3_q;
    logic [EW-1:0] sh3_q, eout3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            fin1_q  <= '0;
            sh1_q   <= '0;
            eout1_q <= '0;
            neg1_q  <= 1'b0;
            sat1_q  <= 1'b0;
            amt1_q  <= '0;
            f2_q    <= '0;
            st2_q   <= 1'b0;
            neg2_q  <= 1'b0;
            fine2_q <= '0;
            sh2_q   <= '0;
            eout2_q <= '0;
            f3_q    <= '0;
            st3_q   <= 1'b0;
            sh3_q   <= '0;
            eout3_q <= '0;
        end else begin
            if (rdy1) v1_q <= io.in_valid;
            if (rdy2) v2_q <= v1_q;
            if (rdy3) v3_q <= v2_q;
            if (ld1) begin
                fin1_q  <= io.fin;
                sh1_q   <= sh1_d;
                eout1_q <= eout1_d;
                neg1_q  <= neg1_d;
                sat1_q  <= sat1_d;
                amt1_q  <= amt1_d;
            end
            if (ld2) begin
                f2_q    <= f2_d;
                st2_q   <= st2_d;
                neg2_q  <= neg1_q;
                fine2_q <= amt1_q[2:0];
                sh2_q   <= sh1_q;
                eout2_q <= eout1_q;
            end
            if (ld3) begin
                f3_q    <= f3_d;
                st3_q   <= st3_d;
                sh3_q   <= sh2_q;
                eout3_q <= eout2_q;
            end
        end
    end

    assign io.in_ready  = rdy1;
    assign io.out_valid = v3_q;
    assign io.sh        = sh3_q;
    assign io.fout      = f3_q;
    assign io.eout      = eout3_q;
    assign io.sticky    = st3_q;
endmodule

// File: doc/rounder_normshift.md
# rounder_normshift

Pipelined, parametrised normalisation-shift stage for the rounder. For each operand it computes the signed shift distance from exponent, leading-zero count, format and underflow-trap state, shifts the significand left (normalise) or right (denormalise), and derives a sticky bit and the adjusted exponent. It sits between the leading-zero counter and the round-increment stage, generalising the combinational shift-distance logic to three formats, a full shifter and valid/ready flow control.

## Interface
- EW, 13: exponent width, two's complement
- LZW, 6: leading-zero count width, unsigned
- FW, 64: significand width
- EMIN_H, -14: minimum exponent, half format
- EMIN_S, -126: minimum exponent, single format
- EMIN_D, -1022: minimum exponent, double format
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input operand valid
- in_ready  out  1  stage can accept an operand this cycle
- er  in  EW  unnormalised exponent
- lz  in  LZW  leading zeros of fin
- fin  in  FW  significand, MSB-aligned
- fmt  in  2  00 half, 01 single, 10 double, 11 reserved (treated as double)
- tiny  in  1  result is tiny
- unfen  in  1  underflow trap enabled
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- sh  out  EW  signed shift distance; positive = left, negative = right
- fout  out  FW  shifted significand
- eout  out  EW  adjusted exponent
- sticky  out  1  OR of all bits shifted out on a right shift

## Operation
- Shift distance: emin = EMIN for fmt. If tiny && !unfen: sh = er - emin. Otherwise sh = zero-extended lz. All arithmetic is EW-bit two's complement.
- eout = er - sh, which is emin in the denormalising case and er - lz otherwise.
- sh >= 0: fout = fin << sh, with zeros shifted in. If sh >= FW, fout = 0. sticky = 0.
- sh < 0: d = -sh. fout = fin >> d, with zeros shifted in. sticky = OR of fin[d-1:0]. If d >= FW, fout = 0 and sticky = |fin.
- Pipeline, three register stages:
  - S1: latch inputs, compute sh, eout and the shift direction.
  - S2: coarse shift by sh[high bits] (multiples of 8); accumulate partial sticky.
  - S3: fine shift by sh[2:0]; finalise sticky.
  - Outputs are driven directly from S3 registers.
- Each stage has a valid bit. A stage loads when it is empty or its contents advance this cycle (bubble collapsing).
- in_ready = !v1 || S1 advances. A stage advances when the next stage is empty or advancing. S3 advances when out_ready is high.
- A transfer occurs on a cycle where valid && ready is high. Data in a stage is held unchanged while stalled.
- Ordering is strictly FIFO. No operand is dropped or duplicated.

## Timing
- Reset values: v1 = v2 = v3 = 0, out_valid = 0, in_ready = 1 in the cycle after reset, and sh = fout = eout = 0, sticky = 0.
- Reset mid-operation: every in-flight operand is discarded and no out_valid follows. Inputs sampled during rst are ignored.
- Latency: an operand accepted at edge N is captured in S1 at N, reaches S3 at N+2, and drives out_valid after N+2, provided there are no stalls.
- Throughput: one operand per cycle while out_ready = 1.
- Capacity: 3 operands. With out_ready held low, in_ready falls after the 3rd accept and stays low until an S3 transfer.
- Simultaneous out transfer and in accept on a full pipe: all stages shift and in_ready stays high.
- out_valid and the data outputs remain stable while out_valid && !out_ready.
- in_ready depends combinationally on out_ready. There is no combinational path from in_valid to out_valid.

## Test plan
- Normal, double: er=5, lz=4, fin=0x0800_0000_0000_0000, tiny=0 -> sh=4, fout=0x8000_0000_0000_0000, eout=1, sticky=0, out_valid 3 cycles after accept.
- Tiny, double, unfen=0: er=-1030, fin=0x8000_0000_0000_00FF -> sh=-8, fout=0x0080_0000_0000_0000, eout=-1022, sticky=1.
- Tiny, single, unfen=0: er=-130, fin=0xF000_0000_0000_0000 -> sh=-4, fout=0x0F00_0000_0000_0000, eout=-126, sticky=0. The same operand with unfen=1, lz=0 -> sh=0, fout=fin, eout=-130.
- Saturating right shift: er=-1200 (double), tiny=1, unfen=0, fin=0x1 -> sh=-178, fout=0, sticky=1, eout=-1022. Half format with er=-20 -> sh=-6, eout=-14.
- Backpressure: 5 back-to-back operands with out_ready=0 for 6 cycles -> in_ready low after the 3rd accept. After release, outputs appear in order with no loss or duplication and are held stable while stalled.
- Reset mid-flight: assert rst for 1 cycle with 3 operands in flight -> out_valid=0 the next cycle, no stale results afterwards, and in_ready=1.
